mem_arbiter: RTL and testbench

Two-master arbiter sharing the single main-memory port between the instruction cache's miss-refill path and the data cache's read/write-back path. It sits between both caches and the memory model, grants one requester at a time, and routes address, data and the `mem_ready` handshake. Requesters see the same hold-until-ready protocol they would see from memory directly.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, the D-cache, the shared memory port and mem_arbiter.
// The master modport is the environment side (caches plus memory); the arbiter uses the slave modport.
interface mem_arbiter_if;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic [31:0] ic_rdata;
   logic        ic_ready;
   logic        dc_rreq;
   logic        dc_wreq;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [31:0] dc_rdata;
   logic        dc_ready;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output ic_req, ic_addr, dc_rreq, dc_wreq, dc_addr, dc_wdata, mem_rdata, mem_ready,
      input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_re, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  ic_req, ic_addr, dc_rreq, dc_wreq, dc_addr, dc_wdata, mem_rdata, mem_ready,
      output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_re, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single memory port (I-cache refill vs D-cache read/write-back).
// Define MEM_ARB_RR_EN for round-robin contention; default is D-priority with an I-side starvation limit.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic         cpu_clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IC = 2'd1,
      GNT_DC = 2'd2
   } state_t;

   state_t state;
   logic   dc_req;
   logic   pick_ic;

`ifdef MEM_ARB_RR_EN
   logic       last_ic;
`else
   logic [7:0] starve_cnt;
`endif

   assign dc_req = bus.dc_rreq | bus.dc_wreq;

   // Arbitration decision used only while IDLE
   always_comb begin
      pick_ic = 1'b0;
      if (bus.ic_req && !dc_req) begin
         pick_ic = 1'b1;
      end else if (bus.ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
         pick_ic = ~last_ic;
`else
         pick_ic = (32'(starve_cnt) >= STARVE_LIMIT);
`endif
      end else begin
         pick_ic = 1'b0;
      end
   end

   // Grant state machine and fairness bookkeeping
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state <= IDLE;
`ifdef MEM_ARB_RR_EN
         last_ic <= 1'b0;
`else
         starve_cnt <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_ic) begin
                  state <= GNT_IC;
`ifdef MEM_ARB_RR_EN
                  last_ic <= 1'b1;
`else
                  starve_cnt <= 8'd0;
`endif
               end else if (dc_req) begin
                  state <= GNT_DC;
`ifdef MEM_ARB_RR_EN
                  last_ic <= 1'b0;
`else
                  // Counts D grants that made a waiting I request wait; saturates
                  if (bus.ic_req && (starve_cnt != 8'd255)) begin
                     starve_cnt <= starve_cnt + 8'd1;
                  end else begin
                     starve_cnt <= starve_cnt;
                  end
`endif
               end else begin
                  state <= IDLE;
               end
            end
            GNT_IC: begin
               if (bus.mem_ready || !bus.ic_req) begin
                  state <= IDLE;
               end else begin
                  state <= GNT_IC;
               end
            end
            GNT_DC: begin
               if (bus.mem_ready || !dc_req) begin
                  state <= IDLE;
               end else begin
                  state <= GNT_DC;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Route the granted requester onto the memory port
   always_comb begin
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      bus.ic_ready  = 1'b0;
      bus.dc_ready  = 1'b0;
      case (state)
         GNT_IC: begin
            bus.mem_re   = bus.ic_req;
            bus.mem_addr = bus.ic_addr;
            bus.ic_ready = bus.mem_ready;
         end
         GNT_DC: begin
            // A simultaneous read and write request resolves to the write
            bus.mem_we    = bus.dc_wreq;
            bus.mem_re    = bus.dc_rreq & ~bus.dc_wreq;
            bus.mem_addr  = bus.dc_addr;
            bus.mem_wdata = bus.dc_wdata;
            bus.dc_ready  = bus.mem_ready;
         end
         default: begin
            bus.mem_re = 1'b0;
         end
      endcase
   end

   assign bus.ic_rdata = bus.mem_rdata;
   assign bus.dc_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level owner/fairness model.
module tb_mem_arbiter;

   localparam int LIMIT = 2;
`ifdef MEM_ARB_RR_EN
   localparam int NG = 4;
   int exp_order [NG] = '{1, 2, 1, 2};
`else
   localparam int NG = 6;
   int exp_order [NG] = '{2, 2, 1, 2, 2, 1};
`endif

   logic cpu_clk = 1'b0;
   logic reset;

   always #5 cpu_clk = ~cpu_clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .bus     (bus)
   );

   // model: who owns the port (0 nobody, 1 I-cache, 2 D-cache) and fairness history
   int   own;
   int   streak;
   bit   last_ic;
   int   mem_lat;
   int   age;
   bit   ic_cont, dc_cont;
   bit   fix_en;
   logic [31:0] fix_rdata;
   logic exp_re, exp_we, exp_icr, exp_dcr;
   logic [31:0] exp_addr, exp_wdata;
   logic obs_re, obs_we, obs_icr, obs_dcr;
   logic [31:0] obs_addr, obs_wdata, obs_icrd, obs_dcrd;
   int   obs_grants[$];
   bit   prev_strobe;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int arbitrate(input bit ic, input bit dc);
      if (ic && dc) begin
`ifdef MEM_ARB_RR_EN
         return last_ic ? 2 : 1;
`else
         return (streak >= LIMIT) ? 1 : 2;
`endif
      end
      if (ic) return 1;
      if (dc) return 2;
      return 0;
   endfunction

   // One clock cycle: predict, answer as memory, compare, advance the model
   task automatic step();
      bit dreq;
      int g;
      dreq      = bus.dc_rreq | bus.dc_wreq;
      exp_re    = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = 32'd0;
      exp_wdata = 32'd0;
      if (own == 1) begin
         exp_re   = bus.ic_req;
         exp_addr = bus.ic_addr;
      end else if (own == 2) begin
         exp_we    = bus.dc_wreq;
         exp_re    = bus.dc_rreq & ~bus.dc_wreq;
         exp_addr  = bus.dc_addr;
         exp_wdata = bus.dc_wdata;
      end
      if (exp_re || exp_we) begin
         age++;
         bus.mem_ready = (mem_lat < 0) ? ($urandom_range(2) == 0) : (age > mem_lat);
      end else begin
         age = 0;
         bus.mem_ready = 1'b0;
      end
      bus.mem_rdata = fix_en ? fix_rdata : 32'($urandom);
      exp_icr = (own == 1) && bus.mem_ready;
      exp_dcr = (own == 2) && bus.mem_ready;
      #1;
      obs_re    = bus.mem_re;
      obs_we    = bus.mem_we;
      obs_addr  = bus.mem_addr;
      obs_wdata = bus.mem_wdata;
      obs_icr   = bus.ic_ready;
      obs_dcr   = bus.dc_ready;
      obs_icrd  = bus.ic_rdata;
      obs_dcrd  = bus.dc_rdata;
      check("mem_re", obs_re, exp_re);
      check("mem_we", obs_we, exp_we);
      check("mem_addr", obs_addr, exp_addr);
      check("mem_wdata", obs_wdata, exp_wdata);
      check("ic_ready", obs_icr, exp_icr);
      check("dc_ready", obs_dcr, exp_dcr);
      check("ic_rdata", obs_icrd, bus.mem_rdata);
      check("dc_rdata", obs_dcrd, bus.mem_rdata);
      if (!prev_strobe && (obs_re || obs_we))
         obs_grants.push_back((obs_re && !obs_we && obs_addr == bus.ic_addr) ? 1 : 2);
      prev_strobe = obs_re || obs_we;
      @(posedge cpu_clk);
      if (reset) begin
         own = 0; streak = 0; last_ic = 1'b0;
      end else if (own == 0) begin
         g = arbitrate(bus.ic_req, dreq);
         if (g == 1) begin
            streak = 0; last_ic = 1'b1;
         end else if (g == 2) begin
            if (bus.ic_req && streak < 255) streak++;
            last_ic = 1'b0;
         end
         own = g;
      end else if (bus.mem_ready || (own == 1 ? !bus.ic_req : !dreq)) begin
         own = 0;
      end
      if (bus.mem_ready) age = 0;
      #1;
      if (exp_icr && !ic_cont) bus.ic_req = 1'b0;
      if (exp_dcr && !dc_cont) begin
         bus.dc_rreq = 1'b0;
         bus.dc_wreq = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.ic_req = 1'b0; bus.ic_addr = 32'd0;
      bus.dc_rreq = 1'b0; bus.dc_wreq = 1'b0; bus.dc_addr = 32'd0; bus.dc_wdata = 32'd0;
      bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;
      own = 0; streak = 0; last_ic = 1'b0; age = 0; mem_lat = 0;
      ic_cont = 1'b0; dc_cont = 1'b0; fix_en = 1'b0; fix_rdata = 32'd0; prev_strobe = 1'b0;
      repeat (2) @(posedge cpu_clk);
      #1;

      // reset state, requests held low
      step();
      step();
      check("rst_re", obs_re, 1'b0);
      check("rst_dcr", obs_dcr, 1'b0);
      reset = 1'b0;

      // lone I-cache read, memory answers on the third strobe cycle
      fix_en = 1'b1; fix_rdata = 32'hDEAD_BEEF; mem_lat = 2;
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1040;
      step();
      check("li_arb", obs_re, 1'b0);
      step();
      check("li_re", obs_re, 1'b1);
      check("li_addr", obs_addr, 32'h0000_1040);
      step();
      step();
      check("li_ready", obs_icr, 1'b1);
      check("li_rdata", obs_icrd, 32'hDEAD_BEEF);
      step();
      check("li_idle", obs_re, 1'b0);
      fix_en = 1'b0;

      // D write, then the same with the read request also high
      mem_lat = 0;
      for (int k = 0; k < 2; k++) begin
         bus.dc_wreq = 1'b1; bus.dc_rreq = (k == 1);
         bus.dc_addr = 32'h0000_2000; bus.dc_wdata = 32'h1234_5678;
         step();
         check("dw_arb", obs_we, 1'b0);
         step();
         check("dw_we", obs_we, 1'b1);
         check("dw_re", obs_re, 1'b0);
         check("dw_wdata", obs_wdata, 32'h1234_5678);
         check("dw_ready", obs_dcr, 1'b1);
         step();
         check("dw_single", obs_dcr, 1'b0);
      end

      // continuous contention from a clean reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      ic_cont = 1'b1; dc_cont = 1'b1;
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1040;
      bus.dc_wreq = 1'b1; bus.dc_rreq = 1'b0; bus.dc_addr = 32'h0000_2000;
      obs_grants.delete();
      for (int c = 0; c < 40 && obs_grants.size() < NG; c++) step();
      check("cont_count", obs_grants.size(), NG);
      for (int i = 0; i < NG; i++)
         check("cont_order", (i < obs_grants.size()) ? obs_grants[i] : 0, exp_order[i]);
      ic_cont = 1'b0; dc_cont = 1'b0;
      bus.ic_req = 1'b0; bus.dc_wreq = 1'b0;
      step();
      step();

      // I request abandoned one cycle into its grant
      mem_lat = 10;
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_3000;
      step();
      step();
      check("ab_re_on", obs_re, 1'b1);
      bus.ic_req = 1'b0;
      step();
      check("ab_re_off", obs_re, 1'b0);
      bus.dc_wreq = 1'b1; bus.dc_addr = 32'h0000_4000; bus.dc_wdata = 32'hA5A5_0F0F;
      step();
      step();
      check("ab_next_gnt", obs_we, 1'b1);

      // reset in the middle of the D grant
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      check("mr_we", obs_we, 1'b0);
      check("mr_re", obs_re, 1'b0);
      bus.dc_wreq = 1'b0;
      step();
      step();

      // random traffic with aborts and occasional resets
      mem_lat = -1;
      for (int n = 0; n < 3000; n++) begin
         if (!bus.ic_req && $urandom_range(3) == 0) begin
            bus.ic_req = 1'b1; bus.ic_addr = $urandom;
         end else if (bus.ic_req && $urandom_range(15) == 0) begin
            bus.ic_req = 1'b0;
         end
         if (!(bus.dc_rreq || bus.dc_wreq) && $urandom_range(3) == 0) begin
            {bus.dc_rreq, bus.dc_wreq} = 2'($urandom_range(3, 1));
            bus.dc_addr = $urandom; bus.dc_wdata = $urandom;
         end else if ((bus.dc_rreq || bus.dc_wreq) && $urandom_range(15) == 0) begin
            bus.dc_rreq = 1'b0; bus.dc_wreq = 1'b0;
         end
         reset = ($urandom_range(99) == 0);
         step();
      end
      reset = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
